// File: rtl/broadsync_slave_rx.sv
// BroadSync slave receiver: synchronises the serial bit clock/heartbeat/timecode,
// deserialises and CRC-8 checks each frame, and presents lock/time/accuracy plus status.
module broadsync_slave_rx #(
  parameter int NS_WIDTH       = 30,
  parameter int S_WIDTH        = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bs_clk_in,
  input  logic                          bs_heartbeat_in,
  input  logic                          bs_timecode_in,
  input  logic                          frame_en,
  output logic                          frame_done,
  output logic                          lock_value_out,
  output logic [S_WIDTH+NS_WIDTH+1:0]   time_value_out,
  output logic [7:0]                    clk_accuracy_out,
  output logic                          frame_error
);

  localparam int P   = 1 + S_WIDTH + NS_WIDTH + 8;
  localparam int FB  = P + 8;
  localparam int TW  = S_WIDTH + NS_WIDTH + 2;
  localparam int CW  = $clog2(FB + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NS_WIDTH-1:0] NS_LIMIT = NS_WIDTH'(1_000_000_000);

  typedef enum logic [2:0] {IDLE, WAIT_HB, WAIT_START, SHIFT, CHECK} state_t;

  logic [1:0]     clk_sync_q, clk_sync_d;
  logic [1:0]     hb_sync_q, hb_sync_d;
  logic [1:0]     tc_sync_q, tc_sync_d;
  logic           clk_prev_q, clk_prev_d;
  state_t         state_q, state_d;
  logic [FB-1:0]  shift_q, shift_d;
  logic [7:0]     crc_q, crc_d;
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TOW-1:0] to_cnt_q, to_cnt_d;
  logic           lock_q, lock_d;
  logic [TW-1:0]  time_q, time_d;
  logic [7:0]     acc_q, acc_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic           strobe, hb, tc, crc_fb, frame_good;
  logic [7:0]     crc_next;
  logic [NS_WIDTH-1:0] ns_field;

  assign strobe   = clk_sync_q[1] & ~clk_prev_q;
  assign hb       = hb_sync_q[1];
  assign tc       = tc_sync_q[1];
  assign crc_fb   = crc_q[7] ^ tc;
  assign crc_next = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
  // Frame layout in shift_q (MSB first): lock, seconds, ns, accuracy, crc
  assign ns_field   = shift_q[NS_WIDTH+15:16];
  assign frame_good = (crc_q == shift_q[7:0]) && (ns_field < NS_LIMIT);

  always_comb begin
    clk_sync_d = {clk_sync_q[0], bs_clk_in};
    hb_sync_d  = {hb_sync_q[0], bs_heartbeat_in};
    tc_sync_d  = {tc_sync_q[0], bs_timecode_in};
    clk_prev_d = clk_sync_q[1];
    state_d    = state_q;
    shift_d    = shift_q;
    crc_d      = crc_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    lock_d     = lock_q;
    time_d     = time_q;
    acc_d      = acc_q;
    done_d     = done_q;
    err_d      = err_q;

    if (!frame_en) begin
      state_d = IDLE;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = WAIT_HB;
        WAIT_HB: if (strobe && hb) state_d = WAIT_START;
        WAIT_START: begin
          if (strobe && tc) begin
            shift_d   = '0;
            crc_d     = '0;
            bit_cnt_d = '0;
            to_cnt_d  = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (strobe) begin
            to_cnt_d = '0;
            if (hb) begin
              done_d  = 1'b0;
              err_d   = 1'b1;
              state_d = WAIT_START;
            end else begin
              shift_d   = {shift_q[FB-2:0], tc};
              // CRC covers the payload only, not the trailing crc byte
              if (bit_cnt_q < CW'(P)) crc_d = crc_next;
              bit_cnt_d = bit_cnt_q + 1'b1;
              if (bit_cnt_q == CW'(FB - 1)) state_d = CHECK;
            end
          end else if (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1)) begin
            done_d  = 1'b0;
            err_d   = 1'b1;
            state_d = WAIT_HB;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        CHECK: begin
          if (frame_good) begin
            lock_d = shift_q[FB-1];
            time_d = {2'b00, shift_q[FB-2:16]};
            acc_d  = shift_q[15:8];
            done_d = 1'b1;
            err_d  = 1'b0;
          end else begin
            done_d = 1'b0;
            err_d  = 1'b1;
          end
          state_d = WAIT_HB;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '0;
      hb_sync_q  <= '0;
      tc_sync_q  <= '0;
      clk_prev_q <= 1'b0;
      state_q    <= IDLE;
      shift_q    <= '0;
      crc_q      <= '0;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      lock_q     <= 1'b0;
      time_q     <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      hb_sync_q  <= hb_sync_d;
      tc_sync_q  <= tc_sync_d;
      clk_prev_q <= clk_prev_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      crc_q      <= crc_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      lock_q     <= lock_d;
      time_q     <= time_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign frame_done       = done_q;
  assign frame_error      = err_q;
  assign lock_value_out   = lock_q;
  assign time_value_out   = time_q;
  assign clk_accuracy_out = acc_q;

endmodule

// File: tb/tb_broadsync_slave_rx.sv
// Scoreboard bench for broadsync_slave_rx: expected frame outcomes are queued as
// frames are sent and compared whenever frame_done or frame_error rises.
module tb_broadsync_slave_rx;
  localparam int NS = 30;
  localparam int S  = 48;
  localparam int TO = 1024;
  localparam int P  = 1 + S + NS + 8;
  localparam int FB = P + 8;
  localparam int TW = S + NS + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bs_clk_in = 1'b0, bs_heartbeat_in = 1'b0, bs_timecode_in = 1'b0;
  logic frame_en = 1'b0;
  logic frame_done, lock_value_out, frame_error;
  logic [TW-1:0] time_value_out;
  logic [7:0] clk_accuracy_out;

  broadsync_slave_rx #(.NS_WIDTH(NS), .S_WIDTH(S), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .bs_clk_in(bs_clk_in), .bs_heartbeat_in(bs_heartbeat_in), .bs_timecode_in(bs_timecode_in),
    .frame_en(frame_en), .frame_done(frame_done), .lock_value_out(lock_value_out),
    .time_value_out(time_value_out), .clk_accuracy_out(clk_accuracy_out), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          good;
    logic          lock;
    logic [TW-1:0] tv;
    logic [7:0]    acc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic          m_lock = 1'b0;
  logic [TW-1:0] m_tv = '0;
  logic [7:0]    m_acc = '0;
  logic done_prev = 1'b0, err_prev = 1'b0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Remainder by long division with 8 appended zeros (CRC-8 0x07, init 0)
  function automatic logic [FB-1:0] make_frame(input logic lock, input logic [S-1:0] sec,
                                               input logic [NS-1:0] ns, input logic [7:0] acc,
                                               input logic flip);
    logic [P-1:0]   pl;
    logic [P+7:0]   m;
    pl = {lock, sec, ns, acc};
    m  = {pl, 8'h00};
    for (int i = P + 7; i >= 8; i--)
      if (m[i]) m[i-:9] = m[i-:9] ^ 9'h107;
    return {pl, m[7:0] ^ {7'b0, flip}};
  endfunction

  task automatic expect_frame(input logic good, input logic lock, input logic [S-1:0] sec,
                              input logic [NS-1:0] ns, input logic [7:0] acc);
    exp_t e;
    if (good) begin
      m_lock = lock;
      m_tv   = {2'b00, sec, ns};
      m_acc  = acc;
    end
    e.good = good; e.lock = m_lock; e.tv = m_tv; e.acc = m_acc;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic hb, input logic tc);
    bs_clk_in = 1'b0; bs_heartbeat_in = hb; bs_timecode_in = tc;
    repeat (4) @(posedge clk);
    #1 bs_clk_in = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [FB-1:0] f, input int nbits);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < nbits; i++) send_bit(1'b0, f[FB-1-i]);
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic clear_status();
    frame_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("clr_done", frame_done, 1'b0);
    check("clr_error", frame_error, 1'b0);
    frame_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: each rising status edge is one frame outcome
  always @(negedge clk) begin
    if ((frame_done && !done_prev) || (frame_error && !err_prev)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_outcome", 1'b1, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("frame_done", frame_done, e.good);
        check("frame_error", frame_error, !e.good);
        check("lock", lock_value_out, e.lock);
        check("time", time_value_out, e.tv);
        check("accuracy", clk_accuracy_out, e.acc);
        $display("outcome good=%0b lock=%0b time=%0h acc=%0h", e.good, lock_value_out,
                 time_value_out, clk_accuracy_out);
      end
    end
    done_prev = frame_done;
    err_prev  = frame_error;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [FB-1:0] f;
    logic [S-1:0]  rsec;
    logic [NS-1:0] rns;
    logic [7:0]    racc;

    #1;
    check("rst_done", frame_done, 1'b0);
    check("rst_error", frame_error, 1'b0);
    check("rst_lock", lock_value_out, 1'b0);
    check("rst_time", time_value_out, '0);
    check("rst_acc", clk_accuracy_out, 8'h00);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    frame_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Good frame
    expect_frame(1'b1, 1'b1, 48'h0000_1234_5678, 30'd999_999_999, 8'h21);
    send_frame(make_frame(1'b1, 48'h0000_1234_5678, 30'd999_999_999, 8'h21, 1'b0), FB);
    settle();

    // CRC LSB flipped
    clear_status();
    expect_frame(1'b0, 1'b0, '0, '0, '0);
    send_frame(make_frame(1'b0, 48'h0000_0BAD_BEEF, 30'd5, 8'h77, 1'b1), FB);
    settle();

    // ns out of range with valid CRC
    clear_status();
    expect_frame(1'b0, 1'b0, '0, '0, '0);
    send_frame(make_frame(1'b0, 48'h0000_0000_0001, 30'd1_000_000_000, 8'h10, 1'b0), FB);
    settle();

    // Timeout after 40 payload bits, then a good frame
    clear_status();
    expect_frame(1'b0, 1'b0, '0, '0, '0);
    send_frame(make_frame(1'b1, 48'h1111_2222_3333, 30'd1234, 8'h44, 1'b0), 40);
    repeat (TO + 20) @(posedge clk);
    #1;
    expect_frame(1'b1, 1'b0, 48'h0000_AAAA_5555, 30'd12_345_678, 8'h5A);
    send_frame(make_frame(1'b0, 48'h0000_AAAA_5555, 30'd12_345_678, 8'h5A, 1'b0), FB);
    settle();

    // Heartbeat at payload bit 50, then a full good frame
    expect_frame(1'b0, 1'b0, '0, '0, '0);
    send_frame(make_frame(1'b1, 48'h0, 30'd1, 8'h01, 1'b0), 50);
    send_bit(1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    expect_frame(1'b1, 1'b1, 48'h0000_0000_ABCD, 30'd0, 8'hFF);
    send_frame(make_frame(1'b1, 48'h0000_0000_ABCD, 30'd0, 8'hFF, 1'b0), FB);
    settle();

    // frame_en dropped at payload bit 20
    send_frame(make_frame(1'b0, 48'h9999, 30'd77, 8'h33, 1'b0), 20);
    frame_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("en_done", frame_done, 1'b0);
    check("en_error", frame_error, 1'b0);
    check("en_time", time_value_out, m_tv);
    check("en_lock", lock_value_out, m_lock);
    check("en_acc", clk_accuracy_out, m_acc);
    frame_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset mid-frame
    send_frame(make_frame(1'b1, 48'h7777, 30'd88, 8'h99, 1'b0), 30);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_done", frame_done, 1'b0);
    check("mid_rst_error", frame_error, 1'b0);
    check("mid_rst_lock", lock_value_out, 1'b0);
    check("mid_rst_time", time_value_out, '0);
    check("mid_rst_acc", clk_accuracy_out, 8'h00);
    m_lock = 1'b0; m_tv = '0; m_acc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Random good frame after reset
    rsec = {16'h0, $urandom()};
    rns  = NS'($urandom_range(999_999_999, 0));
    racc = 8'($urandom());
    f = make_frame(1'b1, rsec, rns, racc, 1'b0);
    expect_frame(1'b1, 1'b1, rsec, rns, racc);
    send_frame(f, FB);
    settle();

    repeat (10) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
